// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and widths for the fifo write-port arbiter.
package fifo_wr_arbiter_pkg;

  localparam int unsigned GID_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Increment an index modulo n (n <= 2**GID_W).
  function automatic logic [GID_W-1:0] wrap_inc(input logic [GID_W-1:0] v,
                                                input int unsigned n);
    logic [GID_W:0] s;
    s = {1'b0, v} + (GID_W+1)'(1);
    return (s >= (GID_W+1)'(n)) ? '0 : s[GID_W-1:0];
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after i_ptr, wrapping modulo NREQ.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [GID_W-1:0] i_ptr,
  output logic [GID_W-1:0] o_idx,
  output logic             o_any
);

  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_shift;
  logic [NREQ-1:0]   w_rot;
  logic [GID_W-1:0]  w_off;
  logic [GID_W:0]    w_sum;

  // Rotate so i_ptr lands at bit 0, priority-encode, then rotate the index back.
  always_comb begin
    w_dbl   = {i_req, i_req};
    w_shift = w_dbl >> i_ptr;
    w_rot   = w_shift[NREQ-1:0];
    w_off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = GID_W'(i);
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= (GID_W+1)'(NREQ)) w_sum = w_sum - (GID_W+1)'(NREQ);
    o_idx = w_sum[GID_W-1:0];
    o_any = |i_req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the single fifo write port between NREQ producers using round-robin
// grants with bounded bursts; stalls the grantee while the fifo is full.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  output logic [DW-1:0]      fifo_in,
  output logic               fifo_wr_en,
  output logic [GID_W-1:0]   grant_id,
  output logic               busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [GID_W-1:0] r_rr_ptr;
  logic [GID_W-1:0] w_rr_ptr_nxt;
  logic [GID_W-1:0] r_grant_id;
  logic [GID_W-1:0] w_grant_id_nxt;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] w_beat_cnt_nxt;

  logic [GID_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_sel_valid;
  logic [DW-1:0]    w_sel_data;
  logic             w_fire;

  fifo_wr_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Grantee's valid and data slice.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_grant_id == GID_W'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_data  = req_data[i*DW +: DW];
      end
    end
  end

  // Write-port outputs are combinational from the registered state so reset clears them at once.
  always_comb begin
    w_fire     = (r_state == ST_GRANT) && w_sel_valid && !fifo_full;
    fifo_wr_en = w_fire;
    fifo_in    = (r_state == ST_GRANT) ? w_sel_data : '0;
    busy       = (r_state == ST_GRANT);
    grant_id   = r_grant_id;
    req_ready  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = w_fire && (r_grant_id == GID_W'(i));
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_grant_id_nxt = r_grant_id;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_grant_id_nxt = w_pick_idx;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A dropped requester ends the grant even under full; full alone just holds.
        if (!w_sel_valid) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = wrap_inc(r_grant_id, NREQ);
        end else if (w_fire) begin
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
          if (r_beat_cnt == LAST_BEAT) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = wrap_inc(r_grant_id, NREQ);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

endmodule
